// File: rtl/demux_1x4_4bit_if.sv
// demux_1x4_4bit_if: producer-side word/select handshake plus four consumer channels
interface demux_1x4_4bit_if;
    logic [3:0] i;
    logic       s0;
    logic       s1;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out0;
    logic [3:0] out1;
    logic [3:0] out2;
    logic [3:0] out3;
    logic       v0;
    logic       v1;
    logic       v2;
    logic       v3;
    logic       r0;
    logic       r1;
    logic       r2;
    logic       r3;
    modport slave (
        input  i, s0, s1, in_valid, r0, r1, r2, r3,
        output in_ready, out0, out1, out2, out3, v0, v1, v2, v3
    );
    modport master (
        output i, s0, s1, in_valid, r0, r1, r2, r3,
        input  in_ready, out0, out1, out2, out3, v0, v1, v2, v3
    );
endinterface

// File: rtl/demux_1x4_4bit.sv
// demux_1x4_4bit: registered 1-to-4 word demux with a one-entry valid/ready holding register per channel
module demux_1x4_4bit (
    input  logic                   clk,
    input  logic                   rst_n,
    demux_1x4_4bit_if.slave        bus
);
    logic [1:0]      k;
    logic [3:0]      r;
    logic            acc;
    logic [3:0]      v_q, v_d;
    logic [3:0][3:0] out_q, out_d;
    assign k            = {bus.s1, bus.s0};
    assign r            = {bus.r3, bus.r2, bus.r1, bus.r0};
    assign bus.in_ready = !v_q[k] | r[k];
    assign acc          = bus.in_valid & bus.in_ready;
    assign bus.out0     = out_q[0];
    assign bus.out1     = out_q[1];
    assign bus.out2     = out_q[2];
    assign bus.out3     = out_q[3];
    assign {bus.v3, bus.v2, bus.v1, bus.v0} = v_q;
    // a load to a channel wins over its drain, so drain+load keeps it full with the new word
    always_comb begin
        v_d   = v_q;
        out_d = out_q;
        for (int j = 0; j < 4; j++) begin
            v_d[j]   = (acc && k == 2'(j)) ? 1'b1 : (v_q[j] & r[j]) ? 1'b0 : v_q[j];
            out_d[j] = (acc && k == 2'(j)) ? bus.i : out_q[j];
        end
    end
    // channel flags and holding registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            out_q <= '0;
        end else begin
            v_q   <= v_d;
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_demux_1x4_4bit.sv
// tb_demux_1x4_4bit: table-driven directed vectors plus async reset sequences
module tb_demux_1x4_4bit;
    typedef struct {
        logic [1:0]  s;
        logic [3:0]  i;
        logic        val;
        logic [3:0]  r;
        logic        rdy;
        logic [3:0]  v;
        logic [15:0] o;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[16];
    vec_t fill[4];

    demux_1x4_4bit_if bus ();
    demux_1x4_4bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        {bus.s1, bus.s0} = t.s;
        bus.i            = t.i;
        bus.in_valid     = t.val;
        {bus.r3, bus.r2, bus.r1, bus.r0} = t.r;
    endtask

    task automatic apply(input string name, input vec_t t);
        drive(t);
        #1;
        chk({name, " in_ready"}, 16'(bus.in_ready), 16'(t.rdy));
        @(posedge clk);
        #1;
        chk({name, " v"}, 16'({bus.v3, bus.v2, bus.v1, bus.v0}), 16'(t.v));
        chk({name, " out"}, {bus.out3, bus.out2, bus.out1, bus.out0}, t.o);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, " v"}, 16'({bus.v3, bus.v2, bus.v1, bus.v0}), 16'h0);
        chk({name, " out"}, {bus.out3, bus.out2, bus.out1, bus.out0}, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            {bus.s1, bus.s0} = 2'(k);
            #0.1;
            chk({name, " in_ready"}, 16'(bus.in_ready), 16'h1);
        end
    endtask

    initial begin
        //            s     i      val   r        rdy   v        {out3,out2,out1,out0}
        tbl[0]  = '{2'd0, 4'hA, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'h000A};
        tbl[1]  = '{2'd1, 4'hF, 1'b1, 4'b0000, 1'b1, 4'b0011, 16'h00FA};
        tbl[2]  = '{2'd2, 4'h0, 1'b1, 4'b0000, 1'b1, 4'b0111, 16'h00FA};
        tbl[3]  = '{2'd3, 4'h5, 1'b1, 4'b0000, 1'b1, 4'b1111, 16'h50FA};
        tbl[4]  = '{2'd2, 4'h3, 1'b1, 4'b0000, 1'b0, 4'b1111, 16'h50FA};
        tbl[5]  = '{2'd2, 4'h3, 1'b1, 4'b0100, 1'b1, 4'b1111, 16'h53FA};
        tbl[6]  = '{2'd3, 4'h9, 1'b1, 4'b1000, 1'b1, 4'b1111, 16'h93FA};
        tbl[7]  = '{2'd3, 4'h6, 1'b1, 4'b1000, 1'b1, 4'b1111, 16'h63FA};
        tbl[8]  = '{2'd0, 4'hE, 1'b0, 4'b0001, 1'b1, 4'b1110, 16'h63FA};
        tbl[9]  = '{2'd0, 4'hE, 1'b0, 4'b0001, 1'b1, 4'b1110, 16'h63FA};
        tbl[10] = '{2'd1, 4'hE, 1'b0, 4'b0010, 1'b1, 4'b1100, 16'h63FA};
        tbl[11] = '{2'd2, 4'h7, 1'b1, 4'b0000, 1'b0, 4'b1100, 16'h63FA};
        tbl[12] = '{2'd1, 4'h7, 1'b1, 4'b0000, 1'b1, 4'b1110, 16'h637A};
        tbl[13] = '{2'd0, 4'hB, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h637A};
        tbl[14] = '{2'd3, 4'h2, 1'b1, 4'b1111, 1'b1, 4'b1000, 16'h237A};
        tbl[15] = '{2'd3, 4'h4, 1'b1, 4'b1000, 1'b1, 4'b1000, 16'h437A};
        fill[0] = '{2'd0, 4'h1, 1'b1, 4'b0000, 1'b1, 4'b1001, 16'h4371};
        fill[1] = '{2'd1, 4'h2, 1'b1, 4'b0000, 1'b1, 4'b1011, 16'h4321};
        fill[2] = '{2'd2, 4'h5, 1'b1, 4'b0000, 1'b1, 4'b1111, 16'h4521};
        fill[3] = '{2'd0, 4'h8, 1'b0, 4'b0000, 1'b1, 4'b1111, 16'h4521};

        drive('{2'd0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'b0000, 16'h0});
        #12;
        chk_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 16; n++) apply($sformatf("vec%0d", n), tbl[n]);

        for (int n = 0; n < 3; n++) apply($sformatf("fill%0d", n), fill[n]);
        {bus.s1, bus.s0} = 2'd3;
        #1;
        chk("full in_ready k3 r3=0", 16'(bus.in_ready), 16'h0);
        @(posedge clk);
        #3;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_reset", '{2'd3, 4'hC, 1'b1, 4'b0000, 1'b1, 4'b1000, 16'hC000});

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
